tlc_config_shifter: RTL and testbench
=====================================

Name: tlc_config_shifter

Overview:
- Receiving end of the configuration-load interface. Accepts numbered configuration words on the store_config / config_number / config_data strobe into an internal word buffer.
- On a shift_start request, serialises the whole buffer to the TLC5951 chain (SIN/SCLK/XLAT). Reports progress on shift_ready.
- Sits between the configuration/pixel sequencer and the LED driver pins.

Parameters:
- NUM_WORDS, 130, number of buffered words (legal range 1..256).
- WORD_W, 24, bits per word.
- IDX_W, 8, width of config_number.
- SCLK_HALF, 2, clk cycles per SCLK half-period (>=1).
- XLAT_CYCLES, 2, clk cycles XLAT is held high after the last bit (>=1).

Ports:
- clk  in  1  system clock (30 MHz)
- rst  in  1  asynchronous reset, active-high
- config_data  in  WORD_W  word to store
- config_number  in  IDX_W  buffer index for config_data
- store_config  in  1  single-cycle write strobe
- config_select  in  1  mode select, sampled with shift_start
- shift_start  in  1  single-cycle shift request
- shift_ready  out  1  1 = idle, request accepted
- tlc_sin  out  1  serial data to TLC5951 SIN
- tlc_sclk  out  1  serial clock to TLC5951
- tlc_xlat  out  1  latch pulse to TLC5951
- tlc_mode  out  1  registered copy of config_select for the frame
- store_overrun  out  1  sticky: a write was dropped

Behaviour:
- Reset values (asynchronous, while rst=1):
  - shift_ready=1, tlc_sin=0, tlc_sclk=0, tlc_xlat=0, tlc_mode=0, store_overrun=0, state=IDLE, all counters 0.
  - Buffer contents are not cleared by reset. Reset mid-shift aborts the frame immediately with no XLAT.
- Buffer writes:
  - A write occurs on a clk edge with store_config=1, state=IDLE and config_number<NUM_WORDS: mem[config_number] <= config_data.
  - store_config=1 in any non-IDLE state: the write is dropped and store_overrun <= 1. store_overrun is cleared only by rst.
  - config_number>=NUM_WORDS: the write is dropped silently and store_overrun is unchanged.
  - Simultaneous store_config and shift_start in IDLE: the write is performed first, and the shifted frame includes the new word.
- State machine, states IDLE -> LOAD -> SHIFT -> LATCH -> IDLE:
  - IDLE:
    - shift_start=1 -> LOAD. shift_ready <= 0, tlc_mode <= config_select, word index <= NUM_WORDS-1.
    - shift_start in any other state is ignored.
  - LOAD (1 cycle): shreg <= mem[NUM_WORDS-1], tlc_sin <= its MSB, tlc_sclk <= 0, bit counter <= WORD_W-1 -> SHIFT.
  - SHIFT, per bit:
    - tlc_sclk is low for SCLK_HALF cycles, then high for SCLK_HALF cycles.
    - At the end of the high phase, tlc_sclk <= 0 and tlc_sin <= next bit, both on the same edge.
    - tlc_sin is stable throughout each rising SCLK edge.
  - Bit order:
    - Words are sent from index NUM_WORDS-1 down to 0, MSB first.
    - The next word is loaded from the buffer on the edge after the last bit of the current word, with no SCLK gap between words.
  - SHIFT exit: after the high phase of bit 0 of word 0, tlc_sclk <= 0, tlc_sin <= 0, tlc_xlat <= 1 -> LATCH.
  - LATCH: tlc_xlat is held for XLAT_CYCLES cycles. Then tlc_xlat <= 0, shift_ready <= 1 -> IDLE.
- Timing:
  - shift_ready is low for exactly 1 + 2*SCLK_HALF*NUM_WORDS*WORD_W + XLAT_CYCLES cycles.
  - SCLK produces exactly NUM_WORDS*WORD_W rising edges per frame.
  - tlc_mode is held from the shift_start edge until the next accepted shift_start.
- Counters: word index uses IDX_W bits, bit counter uses ceil(log2(WORD_W)) bits, phase counter uses ceil(log2(SCLK_HALF+1)) bits. There is no wrap-around; each counter is reloaded per word or bit.

Test Plan:
1. NUM_WORDS=2, WORD_W=4, SCLK_HALF=1, XLAT_CYCLES=1. Write mem[1]=4'hA, mem[0]=4'h5, then pulse shift_start -> tlc_sin sampled at the 8 rising tlc_sclk edges = 1,0,1,0,0,1,0,1. shift_ready is low for exactly 18 cycles. One tlc_xlat pulse of 1 cycle starts the edge after the 8th SCLK high phase ends.
2. Default parameters with the full 130-word buffer, each word = its index -> 3120 SCLK rising edges. The captured stream equals words 129..0, MSB first. shift_ready is low for 1+12480+2 = 12483 cycles.
3. store_config pulse mid-SHIFT with config_number=0 and data 24'hFFFFFF -> frame data is unchanged and store_overrun=1. A second frame still shows the old mem[0].
4. Write with config_number=200 (NUM_WORDS=130) -> no buffer change and store_overrun stays 0. Second shift_start pulsed during SHIFT -> ignored, exactly one frame is sent.
5. config_select=1 with shift_start -> tlc_mode=1 for the whole frame. store_config and shift_start in the same IDLE cycle -> the new word appears in the frame.
6. rst asserted mid-SHIFT -> all outputs take reset values asynchronously and no XLAT occurs. After release, a new frame reproduces the pre-reset buffer contents.

Source files
------------

// File: rtl/tlc_config_shifter.sv
// Configuration word buffer plus a serialiser that sends every word to a TLC5951 chain
// (SIN/SCLK/XLAT), highest index first and MSB first, then pulses XLAT once.
module tlc_config_shifter #(
    parameter int NUM_WORDS   = 130,
    parameter int WORD_W      = 24,
    parameter int IDX_W       = 8,
    parameter int SCLK_HALF   = 2,
    parameter int XLAT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] config_data,
    input  logic [IDX_W-1:0]  config_number,
    input  logic              store_config,
    input  logic              config_select,
    input  logic              shift_start,
    output logic              shift_ready,
    output logic              tlc_sin,
    output logic              tlc_sclk,
    output logic              tlc_xlat,
    output logic              tlc_mode,
    output logic              store_overrun
);

    localparam int AW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int PH_W  = $clog2(SCLK_HALF + 1);
    localparam int XL_W  = (XLAT_CYCLES > 1) ? $clog2(XLAT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_WORD   = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W:0]   NUM_WORDS_L = (IDX_W + 1)'(NUM_WORDS);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(WORD_W - 1);
    localparam logic [PH_W-1:0]  PH_END      = PH_W'(SCLK_HALF - 1);
    localparam logic [XL_W-1:0]  XL_END      = XL_W'(XLAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [XL_W-1:0]    xlat_cnt_q, xlat_cnt_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic               shift_ready_q, shift_ready_d;
    logic               sclk_q, sclk_d;
    logic               xlat_q, xlat_d;
    logic               mode_q, mode_d;
    logic               overrun_q, overrun_d;

    logic [WORD_W-1:0]  mem [NUM_WORDS];
    logic               mem_we;
    logic [IDX_W-1:0]   rd_idx;
    logic [WORD_W-1:0]  rd_data;
    logic [WORD_W-1:0]  shreg_shifted;

    // The buffer is never reset so a frame can be resent after a reset.
    assign mem_we = store_config && (state_q == IDLE) && ({1'b0, config_number} < NUM_WORDS_L);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[config_number[AW-1:0]] <= config_data;
        end
    end

    // LOAD fetches the top word; during SHIFT the next-lower word is prefetched.
    assign rd_idx        = (state_q == LOAD) ? word_idx_q : word_idx_q - 1'b1;
    assign rd_data       = mem[rd_idx[AW-1:0]];
    assign shreg_shifted = shreg_q << 1;

    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        bit_cnt_d     = bit_cnt_q;
        phase_d       = phase_q;
        xlat_cnt_d    = xlat_cnt_q;
        shreg_d       = shreg_q;
        shift_ready_d = shift_ready_q;
        sclk_d        = sclk_q;
        xlat_d        = xlat_q;
        mode_d        = mode_q;
        overrun_d     = overrun_q;

        if (store_config && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (shift_start) begin
                    state_d       = LOAD;
                    shift_ready_d = 1'b0;
                    mode_d        = config_select;
                    word_idx_d    = LAST_WORD;
                end
            end
            LOAD: begin
                shreg_d   = rd_data;
                sclk_d    = 1'b0;
                bit_cnt_d = LAST_BIT;
                phase_d   = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (phase_q != PH_END) begin
                    phase_d = phase_q + 1'b1;
                end else begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling SCLK and the next SIN bit share one edge.
                        sclk_d = 1'b0;
                        if (bit_cnt_q != '0) begin
                            shreg_d   = shreg_shifted;
                            bit_cnt_d = bit_cnt_q - 1'b1;
                        end else if (word_idx_q != '0) begin
                            shreg_d    = rd_data;
                            bit_cnt_d  = LAST_BIT;
                            word_idx_d = word_idx_q - 1'b1;
                        end else begin
                            shreg_d    = '0;
                            xlat_d     = 1'b1;
                            xlat_cnt_d = '0;
                            state_d    = LATCH;
                        end
                    end
                end
            end
            LATCH: begin
                if (xlat_cnt_q != XL_END) begin
                    xlat_cnt_d = xlat_cnt_q + 1'b1;
                end else begin
                    xlat_cnt_d    = '0;
                    xlat_d        = 1'b0;
                    shift_ready_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            word_idx_q    <= '0;
            bit_cnt_q     <= '0;
            phase_q       <= '0;
            xlat_cnt_q    <= '0;
            shreg_q       <= '0;
            shift_ready_q <= 1'b1;
            sclk_q        <= 1'b0;
            xlat_q        <= 1'b0;
            mode_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            bit_cnt_q     <= bit_cnt_d;
            phase_q       <= phase_d;
            xlat_cnt_q    <= xlat_cnt_d;
            shreg_q       <= shreg_d;
            shift_ready_q <= shift_ready_d;
            sclk_q        <= sclk_d;
            xlat_q        <= xlat_d;
            mode_q        <= mode_d;
            overrun_q     <= overrun_d;
        end
    end

    // SIN is the shift register MSB, so it only moves when SCLK falls.
    assign tlc_sin       = shreg_q[WORD_W-1];
    assign tlc_sclk      = sclk_q;
    assign tlc_xlat      = xlat_q;
    assign tlc_mode      = mode_q;
    assign shift_ready   = shift_ready_q;
    assign store_overrun = overrun_q;

endmodule

// File: tb/tb_tlc_config_shifter.sv
// Bench for tlc_config_shifter: a small instance for protocol corners and random frames,
// and a default-sized instance for the full 130-word frame.
module tb_tlc_config_shifter;

    localparam int A_N = 2;
    localparam int A_W = 4;
    localparam int A_H = 1;
    localparam int A_X = 1;
    localparam int A_TOTAL = 1 + 2 * A_H * A_N * A_W + A_X;
    localparam int A_LIMIT = 200;

    localparam int B_N = 130;
    localparam int B_W = 24;
    localparam int B_H = 2;
    localparam int B_X = 2;
    localparam int B_LIMIT = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_a;
    logic [A_W-1:0] config_data_a;
    logic [7:0]     config_number_a;
    logic           store_config_a, config_select_a, shift_start_a;
    logic           shift_ready_a, tlc_sin_a, tlc_sclk_a, tlc_xlat_a, tlc_mode_a, store_overrun_a;

    logic           rst_b;
    logic [B_W-1:0] config_data_b;
    logic [7:0]     config_number_b;
    logic           store_config_b, config_select_b, shift_start_b;
    logic           shift_ready_b, tlc_sin_b, tlc_sclk_b, tlc_xlat_b, tlc_mode_b, store_overrun_b;

    tlc_config_shifter #(
        .NUM_WORDS(A_N), .WORD_W(A_W), .IDX_W(8), .SCLK_HALF(A_H), .XLAT_CYCLES(A_X)
    ) dut_a (
        .clk(clk), .rst(rst_a), .config_data(config_data_a), .config_number(config_number_a),
        .store_config(store_config_a), .config_select(config_select_a), .shift_start(shift_start_a),
        .shift_ready(shift_ready_a), .tlc_sin(tlc_sin_a), .tlc_sclk(tlc_sclk_a), .tlc_xlat(tlc_xlat_a),
        .tlc_mode(tlc_mode_a), .store_overrun(store_overrun_a)
    );

    tlc_config_shifter #(
        .NUM_WORDS(B_N), .WORD_W(B_W), .IDX_W(8), .SCLK_HALF(B_H), .XLAT_CYCLES(B_X)
    ) dut_b (
        .clk(clk), .rst(rst_b), .config_data(config_data_b), .config_number(config_number_b),
        .store_config(store_config_b), .config_select(config_select_b), .shift_start(shift_start_b),
        .shift_ready(shift_ready_b), .tlc_sin(tlc_sin_b), .tlc_sclk(tlc_sclk_b), .tlc_xlat(tlc_xlat_b),
        .tlc_mode(tlc_mode_b), .store_overrun(store_overrun_b)
    );

    typedef struct {
        int low_cnt;
        int xlat_cycles;
        int xlat_pulses;
        int xlat_first;
        int mode_bad;
        bit timed_out;
    } frame_res_t;

    typedef struct {
        logic [3:0] w1;
        logic [3:0] w0;
        logic       sel;
        logic [7:0] exp_bits;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [A_W-1:0] model_a [A_N];
    logic           exp_overrun_a;
    logic [B_W-1:0] model_b [B_N];
    bit             cap_a[$];
    bit             cap_b[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] packA();
        logic [63:0] v = '0;
        foreach (cap_a[i]) v = {v[62:0], cap_a[i]};
        return v;
    endfunction

    // Reference stream: words from the top index down, each MSB first.
    function automatic logic [63:0] expStreamA();
        logic [63:0] v = '0;
        for (int w = A_N - 1; w >= 0; w--)
            for (int b = A_W - 1; b >= 0; b--)
                v = {v[62:0], model_a[w][b]};
        return v;
    endfunction

    task automatic writeA(input logic [7:0] idx, input logic [A_W-1:0] data);
        @(negedge clk);
        store_config_a  = 1'b1;
        config_number_a = idx;
        config_data_a   = data;
        if (int'(idx) < A_N) model_a[idx] = data;
        @(negedge clk);
        store_config_a = 1'b0;
    endtask

    // One frame on instance A with optional same-cycle store and mid-frame store/start/reset.
    task automatic applyStimulus(input logic sel, input bit same_store, input logic [7:0] same_idx,
                                 input logic [A_W-1:0] same_data, input int store_at,
                                 input logic [7:0] store_idx, input logic [A_W-1:0] store_data,
                                 input int start_at, input int rst_at, output frame_res_t r);
        logic prev_sclk, prev_xlat;
        bit   done;
        cap_a.delete();
        r = '{default: 0};
        r.xlat_first = -1;
        @(negedge clk);
        shift_start_a   = 1'b1;
        config_select_a = sel;
        if (same_store) begin
            store_config_a  = 1'b1;
            config_number_a = same_idx;
            config_data_a   = same_data;
            if (int'(same_idx) < A_N) model_a[same_idx] = same_data;
        end
        @(negedge clk);
        shift_start_a  = 1'b0;
        store_config_a = 1'b0;
        prev_sclk = 1'b0;
        prev_xlat = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < A_LIMIT; cyc++) begin
            if (shift_ready_a) begin
                done = 1'b1;
                break;
            end
            r.low_cnt++;
            if (tlc_sclk_a && !prev_sclk) cap_a.push_back(tlc_sin_a);
            if (tlc_xlat_a) begin
                r.xlat_cycles++;
                if (!prev_xlat) begin
                    r.xlat_pulses++;
                    if (r.xlat_first < 0) r.xlat_first = cyc;
                end
            end
            if (tlc_mode_a !== sel) r.mode_bad++;
            prev_sclk = tlc_sclk_a;
            prev_xlat = tlc_xlat_a;
            store_config_a  = (cyc == store_at);
            config_number_a = store_idx;
            config_data_a   = store_data;
            if (cyc == store_at) exp_overrun_a = 1'b1;
            shift_start_a = (cyc == start_at);
            if (cyc == rst_at) begin
                rst_a = 1'b1;
                #1;
                exp_overrun_a = 1'b0;
                checkOutput("rst_mid_ready", shift_ready_a, 1);
                checkOutput("rst_mid_sin", tlc_sin_a, 0);
                checkOutput("rst_mid_sclk", tlc_sclk_a, 0);
                checkOutput("rst_mid_xlat", tlc_xlat_a, 0);
                checkOutput("rst_mid_mode", tlc_mode_a, 0);
                checkOutput("rst_mid_overrun", store_overrun_a, 0);
                store_config_a = 1'b0;
                shift_start_a  = 1'b0;
                @(negedge clk);
                checkOutput("rst_hold_xlat", tlc_xlat_a, 0);
                rst_a = 1'b0;
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        store_config_a = 1'b0;
        shift_start_a  = 1'b0;
        r.timed_out = !done;
    endtask

    task automatic checkFrameA(input string name, input frame_res_t r);
        checkOutput($sformatf("%s_timeout", name), r.timed_out, 0);
        checkOutput($sformatf("%s_ready_low", name), r.low_cnt, A_TOTAL);
        checkOutput($sformatf("%s_xlat_pulses", name), r.xlat_pulses, 1);
        checkOutput($sformatf("%s_xlat_width", name), r.xlat_cycles, A_X);
        checkOutput($sformatf("%s_xlat_start", name), r.xlat_first, 1 + 2 * A_H * A_N * A_W);
        checkOutput($sformatf("%s_mode", name), r.mode_bad, 0);
        checkOutput($sformatf("%s_sclk_edges", name), cap_a.size(), A_N * A_W);
        checkOutput($sformatf("%s_stream", name), packA(), expStreamA());
        checkOutput($sformatf("%s_overrun", name), store_overrun_a, exp_overrun_a);
    endtask

    task automatic runFrameB(output frame_res_t r);
        logic prev_sclk;
        bit   done;
        cap_b.delete();
        r = '{default: 0};
        @(negedge clk);
        shift_start_b = 1'b1;
        @(negedge clk);
        shift_start_b = 1'b0;
        prev_sclk = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < B_LIMIT; cyc++) begin
            if (shift_ready_b) begin
                done = 1'b1;
                break;
            end
            r.low_cnt++;
            if (tlc_sclk_b && !prev_sclk) cap_b.push_back(tlc_sin_b);
            if (tlc_xlat_b) r.xlat_cycles++;
            if (tlc_mode_b !== 1'b0) r.mode_bad++;
            prev_sclk = tlc_sclk_b;
            @(negedge clk);
        end
        r.timed_out = !done;
    endtask

    vec_t       vecs[4];
    frame_res_t res;

    initial begin
        vecs[0] = '{4'hF, 4'h0, 1'b0, 8'hF0};
        vecs[1] = '{4'h3, 4'hC, 1'b1, 8'h3C};
        vecs[2] = '{4'h8, 4'h1, 1'b0, 8'h81};
        vecs[3] = '{4'h6, 4'h9, 1'b1, 8'h69};

        rst_a = 1'b1; rst_b = 1'b1;
        config_data_a = '0; config_number_a = '0; store_config_a = 1'b0;
        config_select_a = 1'b0; shift_start_a = 1'b0;
        config_data_b = '0; config_number_b = '0; store_config_b = 1'b0;
        config_select_b = 1'b0; shift_start_b = 1'b0;
        exp_overrun_a = 1'b0;
        foreach (model_a[i]) model_a[i] = '0;
        repeat (3) @(negedge clk);

        checkOutput("reset_ready", shift_ready_a, 1);
        checkOutput("reset_sin", tlc_sin_a, 0);
        checkOutput("reset_sclk", tlc_sclk_a, 0);
        checkOutput("reset_xlat", tlc_xlat_a, 0);
        checkOutput("reset_mode", tlc_mode_a, 0);
        checkOutput("reset_overrun", store_overrun_a, 0);
        checkOutput("reset_ready_b", shift_ready_b, 1);
        rst_a = 1'b0; rst_b = 1'b0;

        writeA(8'd1, 4'hA);
        writeA(8'd0, 4'h5);
        applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, -1, 8'd0, 4'h0, -1, -1, res);
        checkOutput("t1_stream", packA(), 64'hA5);
        checkOutput("t1_ready_low", res.low_cnt, 18);
        checkOutput("t1_xlat_start", res.xlat_first, 17);
        checkOutput("t1_xlat_width", res.xlat_cycles, 1);
        checkOutput("t1_sclk_edges", cap_a.size(), 8);
        checkFrameA("t1", res);

        for (int v = 0; v < 4; v++) begin
            writeA(8'd1, vecs[v].w1);
            writeA(8'd0, vecs[v].w0);
            applyStimulus(vecs[v].sel, 1'b0, 8'd0, 4'h0, -1, 8'd0, 4'h0, -1, -1, res);
            checkOutput($sformatf("vec%0d_bits", v), packA(), {56'd0, vecs[v].exp_bits});
            checkFrameA($sformatf("vec%0d", v), res);
        end

        writeA(8'd200, 4'h7);
        applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, -1, 8'd0, 4'h0, 5, -1, res);
        checkOutput("t4_overrun", store_overrun_a, 0);
        checkFrameA("t4", res);

        applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 6, 8'd0, 4'hF, -1, -1, res);
        checkOutput("t3_overrun", store_overrun_a, 1);
        checkFrameA("t3a", res);
        applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, -1, 8'd0, 4'h0, -1, -1, res);
        checkFrameA("t3b", res);

        applyStimulus(1'b1, 1'b1, 8'd0, 4'hC, -1, 8'd0, 4'h0, -1, -1, res);
        checkOutput("t5_new_word", packA() & 64'hF, 64'hC);
        checkFrameA("t5", res);

        applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, -1, 8'd0, 4'h0, -1, 7, res);
        checkOutput("t6_no_xlat", res.xlat_pulses, 0);
        applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, -1, 8'd0, 4'h0, -1, -1, res);
        checkFrameA("t6_after", res);

        for (int it = 0; it < 25; it++) begin
            int nw;
            int st_at;
            int sp_at;
            nw = int'($urandom_range(0, 3));
            for (int k = 0; k < nw; k++) writeA(8'($urandom_range(0, 5)), 4'($urandom_range(0, 15)));
            st_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : -1;
            sp_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : -1;
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          8'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), st_at,
                          8'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), sp_at, -1, res);
            checkFrameA($sformatf("rand%0d", it), res);
        end

        for (int i = 0; i < B_N; i++) begin
            @(negedge clk);
            store_config_b  = 1'b1;
            config_number_b = 8'(i);
            config_data_b   = 24'(i);
            model_b[i]      = 24'(i);
        end
        @(negedge clk);
        store_config_b = 1'b0;
        runFrameB(res);
        checkOutput("t2_timeout", res.timed_out, 0);
        checkOutput("t2_ready_low", res.low_cnt, 12483);
        checkOutput("t2_sclk_edges", cap_b.size(), 3120);
        checkOutput("t2_xlat_width", res.xlat_cycles, B_X);
        checkOutput("t2_mode", res.mode_bad, 0);
        begin
            int bad;
            bad = 0;
            for (int w = 0; w < B_N; w++) begin
                logic [B_W-1:0] got;
                got = '0;
                for (int b = 0; b < B_W; b++) begin
                    if (w * B_W + b < cap_b.size()) got = {got[B_W-2:0], cap_b[w * B_W + b]};
                end
                if (got !== model_b[B_N - 1 - w]) bad++;
            end
            checkOutput("t2_word_errors", bad, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
